// File: rtl/input_event_queue.sv
// input_event_queue: front-panel input collector. Synchronises and debounces
// NUM_BTN push-buttons plus the rotary centre switch, decodes the quadrature
// encoder into steps, and queues press/release/rotate event bytes in a
// show-ahead FIFO drained by the I2C slave register logic.
//
// Event byte: {type[1:0], index[5:0]}
//   00 press, 01 release (index = channel), 10 CW, 11 CCW (index = 0).
// Channel NUM_BTN is the rotary centre switch.
module input_event_queue #(
  parameter int unsigned NUM_BTN         = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 350000,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned POS_W           = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_BTN-1:0]            btn,
  input  logic                          rotary_center,
  input  logic                          rotary_a,
  input  logic                          rotary_b,
  input  logic                          evt_rd,
  input  logic                          clr_ovf,
  output logic                          evt_valid,
  output logic [7:0]                    evt_data,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow,
  output logic signed [POS_W-1:0]       position
);

  localparam int unsigned NCH     = NUM_BTN + 1;  // buttons + centre switch
  localparam int unsigned NRAW    = NUM_BTN + 3;  // channels + A + B
  localparam int unsigned NSRC    = NUM_BTN + 2;  // rotary + channels
  localparam int unsigned IDX_A   = NCH;
  localparam int unsigned IDX_B   = NCH + 1;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------
  logic [NRAW-1:0] w_raw;
  logic [NRAW-1:0] r_sync1;
  logic [NRAW-1:0] r_sync2;

  assign w_raw = {rotary_b, rotary_a, rotary_center, btn};

  // Two-flop synchroniser for every asynchronous input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce: one counter per channel, fire pulse on accepted level change
  // ---------------------------------------------------------------------
  logic [NCH-1:0][DB_W-1:0] r_db_cnt;
  logic [NCH-1:0]           r_stable;
  logic [NCH-1:0]           r_fire;

  // Count disagreement cycles; flip the stable level after DEBOUNCE_CYCLES
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db_cnt <= '0;
      r_stable <= '0;
      r_fire   <= '0;
    end else begin
      for (int c = 0; c < int'(NCH); c++) begin
        r_fire[c] <= 1'b0;
        if (r_sync2[c] == r_stable[c]) begin
          r_db_cnt[c] <= '0;
        end else if (r_db_cnt[c] == DB_LAST) begin
          r_db_cnt[c] <= '0;
          r_stable[c] <= r_sync2[c];
          r_fire[c]   <= 1'b1;
        end else begin
          r_db_cnt[c] <= r_db_cnt[c] + DB_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Rotary quadrature filter and position counter
  // ---------------------------------------------------------------------
  logic             w_qa;
  logic             w_qb;
  logic             w_q1_n;
  logic             w_q2_n;
  logic             w_rise;
  logic             r_q1;
  logic             r_q2;
  logic             r_rot_fire;
  logic             r_rot_cw;
  logic [POS_W-1:0] r_pos;

  assign w_qa = r_sync2[IDX_A];
  assign w_qb = r_sync2[IDX_B];

  // q1 tracks the both-high/both-low states, q2 the phase order in between
  always_comb begin
    w_q1_n = r_q1;
    w_q2_n = r_q2;
    if (w_qa && w_qb) begin
      w_q1_n = 1'b1;
    end else if (!w_qa && !w_qb) begin
      w_q1_n = 1'b0;
    end
    if (!w_qa && w_qb) begin
      w_q2_n = 1'b1;
    end else if (w_qa && !w_qb) begin
      w_q2_n = 1'b0;
    end
    w_rise = w_q1_n & ~r_q1;
  end

  // Filter state, step pulse and wrapping position counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q1       <= 1'b0;
      r_q2       <= 1'b0;
      r_rot_fire <= 1'b0;
      r_rot_cw   <= 1'b0;
      r_pos      <= '0;
    end else begin
      r_q1       <= w_q1_n;
      r_q2       <= w_q2_n;
      r_rot_fire <= w_rise;
      if (w_rise) begin
        r_rot_cw <= r_q2;
        r_pos    <= r_q2 ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pending slots (source 0 = rotary, source c+1 = channel c)
  // ---------------------------------------------------------------------
  logic [NSRC-1:0]       w_fire_src;
  logic [NSRC-1:0][7:0]  w_fire_byte;
  logic [NSRC-1:0]       r_pend_vld;
  logic [NSRC-1:0][7:0]  r_pend_data;
  logic [NSRC-1:0]       w_grant;
  logic                  w_push_req;
  logic [7:0]            w_push_byte;
  logic                  w_slot_lost;

  // Encode each source's fire pulse into its event byte
  always_comb begin
    w_fire_src     = '0;
    w_fire_byte    = '0;
    w_fire_src[0]  = r_rot_fire;
    w_fire_byte[0] = {1'b1, ~r_rot_cw, 6'd0};
    for (int c = 0; c < int'(NCH); c++) begin
      w_fire_src[c+1]  = r_fire[c];
      w_fire_byte[c+1] = {1'b0, ~r_stable[c], 6'(c)};
    end
  end

  // Fixed-priority arbiter: lowest source index wins
  always_comb begin
    w_grant     = '0;
    w_push_req  = 1'b0;
    w_push_byte = '0;
    for (int s = int'(NSRC) - 1; s >= 0; s--) begin
      if (r_pend_vld[s]) begin
        w_grant     = '0;
        w_grant[s]  = 1'b1;
        w_push_req  = 1'b1;
        w_push_byte = r_pend_data[s];
      end
    end
  end

  // A fire into a slot that is occupied and not leaving this cycle loses data
  assign w_slot_lost = |(w_fire_src & r_pend_vld & ~w_grant);

  // Slot capture; a new fire takes precedence over the grant clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_vld  <= '0;
      r_pend_data <= '0;
    end else begin
      for (int s = 0; s < int'(NSRC); s++) begin
        if (w_fire_src[s]) begin
          r_pend_vld[s]  <= 1'b1;
          r_pend_data[s] <= w_fire_byte[s];
        end else if (w_grant[s]) begin
          r_pend_vld[s]  <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_n;
  logic             r_valid;
  logic             r_ovf;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;
  logic             w_drop;

  // Push/pop qualification and next occupancy
  always_comb begin
    w_full    = (r_count == CNT_FULL);
    w_do_pop  = evt_rd && (r_count != '0);
    w_do_push = w_push_req && (!w_full || w_do_pop);
    w_drop    = w_push_req && !w_do_push;
    w_count_n = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_n = r_count + CNT_W'(1);
    end else if (!w_do_push && w_do_pop) begin
      w_count_n = r_count - CNT_W'(1);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= w_push_byte;
    end
  end

  // Pointers, occupancy, valid flag and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_n;
      r_valid <= (w_count_n != '0);
      if (w_drop || w_slot_lost) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign evt_valid = r_valid;
  assign evt_data  = r_mem[r_rd_ptr];
  assign evt_count = r_count;
  assign overflow  = r_ovf;
  assign position  = r_pos;

endmodule

// File: tb/tb_input_event_queue.sv
// Scoreboard bench for input_event_queue: stimulus pushes expected event
// bytes, a monitor pops the FIFO and compares in order.
`timescale 1ns/1ps
module tb_input_event_queue;

  localparam int unsigned NUM_BTN = 3;
  localparam int unsigned DB      = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned POS_W   = 8;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_BTN-1:0]        btn;
  logic                      rotary_center;
  logic                      rotary_a;
  logic                      rotary_b;
  logic                      evt_rd;
  logic                      clr_ovf;
  logic                      evt_valid;
  logic [7:0]                evt_data;
  logic [$clog2(DEPTH):0]    evt_count;
  logic                      overflow;
  logic signed [POS_W-1:0]   position;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  bit         drain_en = 1'b0;
  bit         pop_req  = 1'b0;

  input_event_queue #(
    .NUM_BTN(NUM_BTN),
    .DEBOUNCE_CYCLES(DB),
    .FIFO_DEPTH(DEPTH),
    .POS_W(POS_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .rotary_center(rotary_center),
    .rotary_a(rotary_a),
    .rotary_b(rotary_b),
    .evt_rd(evt_rd),
    .clr_ovf(clr_ovf),
    .evt_valid(evt_valid),
    .evt_data(evt_data),
    .evt_count(evt_count),
    .overflow(overflow),
    .position(position)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the n-th next rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v);
    if (ch == int'(NUM_BTN)) rotary_center = v;
    else btn[ch] = v;
  endtask

  // One full quadrature cycle; CW leads with B, CCW leads with A
  task automatic rot(input bit cw, input int hold, input bit expect_evt);
    if (expect_evt) exp_q.push_back(cw ? 8'h80 : 8'hC0);
    if (cw) begin
      rotary_b = 1'b1; tick(hold);
      rotary_a = 1'b1; tick(hold);
      rotary_b = 1'b0; tick(hold);
      rotary_a = 1'b0; tick(hold);
    end else begin
      rotary_a = 1'b1; tick(hold);
      rotary_b = 1'b1; tick(hold);
      rotary_a = 1'b0; tick(hold);
      rotary_b = 1'b0; tick(hold);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: pop whenever allowed and compare the head against the scoreboard
  initial begin
    logic [7:0] exp_b;
    evt_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (evt_valid && (drain_en || pop_req)) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_event: got 0x%02h expected none at %0t", evt_data, $time);
        end else begin
          exp_b = exp_q.pop_front();
          check("evt_data", {24'd0, evt_data}, {24'd0, exp_b});
        end
        evt_rd = 1'b1;
      end else begin
        evt_rd = 1'b0;
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    btn = '0;
    rotary_center = 1'b0;
    rotary_a = 1'b0;
    rotary_b = 1'b0;
    clr_ovf = 1'b0;

    // Reset defaults
    tick(3);
    reset = 1'b1;
    @(negedge clk);
    check("rst_valid", evt_valid, 0);
    check("rst_count", evt_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_pos", $unsigned(position), 0);
    tick(10);
    @(negedge clk);
    check("idle_valid", evt_valid, 0);
    check("idle_count", evt_count, 0);
    check("idle_ovf", overflow, 0);
    check("idle_pos", $unsigned(position), 0);
    tick(1);
    drain_en = 1'b1;

    // Short glitch is rejected
    btn[1] = 1'b1; tick(3);
    btn[1] = 1'b0; tick(14);
    @(negedge clk);
    check("glitch_count", evt_count, 0);
    tick(1);

    // Held press and release on btn[1], then the centre switch
    exp_q.push_back(8'h01);
    btn[1] = 1'b1; tick(10);
    exp_q.push_back(8'h41);
    btn[1] = 1'b0; tick(12);
    wait_drain("drain_btn1");
    exp_q.push_back(8'h03);
    rotary_center = 1'b1; tick(10);
    exp_q.push_back(8'h43);
    rotary_center = 1'b0; tick(12);
    wait_drain("drain_center");

    // One CCW step, then three CW steps
    rot(1'b0, 2, 1'b1);
    tick(4);
    check("pos_ccw", $unsigned(position), 8'hFF);
    for (int i = 0; i < 3; i++) rot(1'b1, 2, 1'b1);
    tick(4);
    check("pos_cw3", $unsigned(position), 8'h02);
    wait_drain("drain_rot");

    // Fast steps up to 127, then wrap to -128
    for (int i = 0; i < 125; i++) rot(1'b1, 1, 1'b1);
    tick(4);
    check("pos_127", $unsigned(position), 8'h7F);
    rot(1'b1, 1, 1'b1);
    tick(4);
    check("pos_wrap", $unsigned(position), 8'h80);
    wait_drain("drain_wrap");

    // Rotary and two buttons fire on the same cycle: priority order
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h02);
    btn[0] = 1'b1; btn[2] = 1'b1; rotary_b = 1'b1;
    tick(3);
    rotary_a = 1'b1; tick(2);
    rotary_b = 1'b0; tick(2);
    rotary_a = 1'b0; tick(12);
    wait_drain("drain_simul");
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h42);
    btn[0] = 1'b0; btn[2] = 1'b0;
    tick(14);
    wait_drain("drain_simul_rel");

    // Fill the FIFO with four presses, lose a fifth event
    drain_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back(8'(c));
      set_ch(c, 1'b1);
      tick(12);
    end
    @(negedge clk);
    check("full_count", evt_count, 4);
    check("full_ovf_pre", overflow, 0);
    tick(1);
    rot(1'b1, 2, 1'b0);
    tick(6);
    @(negedge clk);
    check("drop_count", evt_count, 4);
    check("drop_ovf", overflow, 1);

    // Release of btn[0] reaches the FIFO on the same edge as a pop
    tick(1);
    exp_q.push_back(8'h40);
    btn[0] = 1'b0;
    tick(7);
    pop_req = 1'b1;
    tick(1);
    pop_req = 1'b0;
    @(negedge clk);
    check("poppush_count", evt_count, 4);
    tick(1);
    clr_ovf = 1'b1; tick(1);
    clr_ovf = 1'b0;
    @(negedge clk);
    check("clr_ovf", overflow, 0);
    tick(1);
    drain_en = 1'b1;
    wait_drain("drain_full");

    // Reset with queued events and a debounce in flight
    drain_en = 1'b0;
    set_ch(1, 1'b0); set_ch(2, 1'b0); set_ch(3, 1'b0);
    tick(14);
    @(negedge clk);
    check("preq_count", evt_count, 3);
    tick(1);
    btn[0] = 1'b1;
    tick(3);
    #2;
    reset = 1'b0;
    btn[0] = 1'b0;
    #1;
    check("midrst_valid", evt_valid, 0);
    check("midrst_count", evt_count, 0);
    tick(2);
    reset = 1'b1;
    tick(20);
    @(negedge clk);
    check("post_valid", evt_valid, 0);
    check("post_count", evt_count, 0);
    check("post_ovf", overflow, 0);
    check("post_pos", $unsigned(position), 0);
    tick(1);
    drain_en = 1'b1;
    tick(5);
    check("final_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/input_event_queue.md
# input_event_queue

Parametrised front-panel input collector for the I2C slave: synchronises and debounces `NUM_BTN` push-buttons plus the rotary centre switch, decodes rotary quadrature into direction steps, and queues timestamp-free press/release/rotate events in a show-ahead FIFO. The slave register logic drains the FIFO one byte per I2C read. An absolute rotary position counter is kept alongside. This block generalises the fixed single-encoder, three-button input path to N buttons, configurable debounce time and queue depth, and adds overflow reporting.

## Interface
- `NUM_BTN`, 3: push-button channels (1..62); rotary centre is channel index `NUM_BTN`.
- `DEBOUNCE_CYCLES`, 350000: stable cycles required before a level change is accepted (7 ms at 50 MHz); ≥ 2.
- `FIFO_DEPTH`, 8: event queue entries; power of two, ≥ 2.
- `POS_W`, 8: width of the signed position counter.
- `clk` in 1: system clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `btn` in `NUM_BTN`: raw button levels, active-high, asynchronous.
- `rotary_center` in 1: raw centre-switch level, active-high.
- `rotary_a`, `rotary_b` in 1 each: raw quadrature phases.
- `evt_rd` in 1: pop strobe from the slave register logic.
- `clr_ovf` in 1: clears `overflow`.
- `evt_valid` out 1: FIFO non-empty.
- `evt_data` out 8: head event; {type[7:6], index[5:0]}.
- `evt_count` out log2(`FIFO_DEPTH`)+1: current occupancy.
- `overflow` out 1: sticky; an event was lost.
- `position` out `POS_W`: signed rotary step count.

## Operation
- Every raw input passes through a 2-FF synchroniser.
- **Debounce:** one counter per channel. The counter increments while the synced level ≠ the stable level, and clears to 0 when they are equal. When it reaches `DEBOUNCE_CYCLES`-1:
  - the stable level flips;
  - the counter clears;
  - a one-cycle event fires: type 00 = press (0→1), type 01 = release (1→0); index = channel.
- **Rotary filter:**
  - `q1` is set on a=b=1 and cleared on a=b=0.
  - `q2` is set on a=0,b=1 and cleared on a=1,b=0.
  - Otherwise both hold.
  - On a rising edge of `q1`:
    - if `q2`=1, fire a CW event (type 10, index 0) and `position` += 1;
    - if `q2`=0, fire a CCW event (type 11, index 0) and `position` −= 1.
  - `position` wraps two's-complement.
  - `position` updates even if the event is later dropped.
- **Pending stage:** each source (rotary, channels 0..`NUM_BTN`) has one pending slot with its encoded byte.
  - A new event from a source whose slot is still occupied overwrites the slot and sets `overflow`.
- **Arbiter:** at most one push per cycle. Fixed priority: rotary > channel 0 > … > channel `NUM_BTN`. The granted slot clears in the same cycle it is pushed.
- **FIFO:** show-ahead; `evt_data` = head entry whenever `evt_valid`=1.
  - Push while full, with no pop in the same cycle: the event is discarded, its slot is cleared, and `overflow` is set.
  - Push and pop in the same cycle when full: both occur; count is unchanged.
  - Push and pop in the same cycle when empty: only the push occurs.
  - `evt_rd` while empty is ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **`overflow`:** cleared by `clr_ovf`. If `clr_ovf` and a new loss occur in the same cycle, set wins.

## Timing
- Reset (`reset`=0), asynchronous, forces all of the following:
  - `evt_valid`=0, `evt_count`=0, `overflow`=0, `position`=0;
  - FIFO pointers 0;
  - stable levels 0, debounce counters 0;
  - `q1`=`q2`=0;
  - pending slots empty;
  - synchronisers 0.
- Reset mid-operation discards all queued and pending events. Release is synchronous to `clk` through the normal flop path.
- Button latency: raw edge → event fire = 2 (sync) + `DEBOUNCE_CYCLES` cycles, provided the input is held stable throughout.
- Event fire → pending slot: +1 cycle. Slot → FIFO write: +1 cycle minimum, more if a higher-priority slot is also pending.
- FIFO write → `evt_valid`=1 with `evt_data` valid: the cycle after the write edge.
- Pop: `evt_rd`=1 sampled at edge N. `evt_data` shows the next entry (or `evt_valid`=0) after edge N.
- Rotary: the quadrature state that raises `q1` → `position` updated 3 cycles after the raw edge (2 sync + 1 filter).
- Rotary phases toggling every cycle are accepted.

## Test plan
- **Reset defaults:** apply reset, then release → `evt_valid`=0, `evt_count`=0, `overflow`=0, `position`=0; all outputs stay stable with inputs idle.
- **Debounce** (`DEBOUNCE_CYCLES`=4, `NUM_BTN`=3):
  - `btn[1]` pulse of 3 cycles → no event.
  - `btn[1]` held 10 cycles → `evt_data`=0x01, and a release later gives 0x41.
  - `rotary_center` held → 0x03.
- **Rotary steps:**
  - Sequence a↑, b↑, a↓, b↓ (20 ns apart) → `evt_data`=0xC0, `position`=−1.
  - Three b-first sequences → three 0x80 events, `position`=+2.
  - Wrap check with `POS_W`=8: starting at 127, one CW step → −128.
- **Simultaneous events:** a rotary event and `btn[0]`/`btn[2]` press events fire in the same cycle → FIFO order 0x80, 0x00, 0x02, on consecutive cycles.
- **FIFO full** (`FIFO_DEPTH`=4):
  - Generate 5 events with no reads → `evt_count`=4, `overflow`=1, and the first 4 events are retained in order.
  - Pop and push in the same cycle while full → count stays 4.
  - `clr_ovf` → `overflow`=0.
- **Reset mid-operation:** with 3 queued events and a debounce in progress, assert reset → FIFO is empty, and no event emerges from the interrupted debounce after release.
